// File: rtl/base_mem_wr_arb.sv
// base_mem_wr_arb: initialises every base_mem entry after reset, then round-robin arbitrates write requesters
module base_mem_wr_arb #(
  parameter int width = 1,
  parameter int addr_width = 1,
  parameter int depth = 2**addr_width,
  parameter int nreq = 2,
  parameter logic [width-1:0] init_val = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [nreq-1:0]            i_v,
  output logic [nreq-1:0]            i_r,
  input  logic [nreq*addr_width-1:0] i_wa,
  input  logic [nreq*width-1:0]      i_wd,
  output logic                       o_we,
  output logic [addr_width-1:0]      o_wa,
  output logic [width-1:0]           o_wd,
  output logic                       o_init_done
);
  localparam int pw = nreq > 1 ? $clog2(nreq) : 1;
  // One extra counter bit lets depth == 2**addr_width be reached without wrapping
  localparam logic [addr_width:0] cnt_end = (addr_width+1)'(depth);
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  logic [addr_width:0] cnt;
  logic [pw-1:0] ptr, sel;
  logic hit;
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = 0; i < nreq; i++)
      if (state == RUN && !hit && i_v[(int'(ptr) + i) % nreq]) begin
        hit = 1'b1;
        sel = pw'((int'(ptr) + i) % nreq);
      end
    i_r = hit ? nreq'(1) << sel : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= INIT;
      cnt <= '0;
      ptr <= '0;
      o_we <= 1'b0;
      o_wa <= '0;
      o_wd <= '0;
      o_init_done <= 1'b0;
    end else if (state == INIT) begin
      if (cnt == cnt_end) begin
        o_we <= 1'b0;
        o_init_done <= 1'b1;
        state <= RUN;
      end else begin
        o_we <= 1'b1;
        o_wa <= cnt[addr_width-1:0];
        o_wd <= init_val;
        cnt <= cnt + 1'b1;
      end
    end else begin
      o_we <= hit;
      if (hit) begin
        o_wa <= i_wa[int'(sel)*addr_width +: addr_width];
        o_wd <= i_wd[int'(sel)*width +: width];
        ptr <= pw'((int'(sel) + 1) % nreq);
      end
    end
endmodule
